// File: rtl/reflet_peripheral_bridge.sv
// reflet_peripheral_bridge: serialises a wordsize-bit CPU access into
// wordsize/8 little-endian byte accesses on an 8-bit peripheral bus.
// Optional feature: define REFLET_BRIDGE_BYTE_ACCESS_EN to add the
// cpu_byte_access input (single-byte access, zero-extended read data).
module reflet_peripheral_bridge #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef REFLET_BRIDGE_BYTE_ACCESS_EN
  input  logic                      cpu_byte_access,
`endif
  input  logic                      cpu_req,
  input  logic [base_addr_size-1:0] cpu_addr,
  input  logic [wordsize-1:0]       cpu_data_in,
  input  logic                      cpu_write_en,
  output logic [wordsize-1:0]       cpu_data_out,
  output logic                      cpu_ready,
  output logic                      per_enable,
  output logic [base_addr_size-1:0] per_addr,
  output logic [7:0]                per_data_out,
  input  logic [7:0]                per_data_in,
  output logic                      per_write_en
);

  localparam int unsigned NBYTES = wordsize / 8;
  // Byte index width: enough for the largest legal word (8 bytes).
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                    state_q;
  logic [KW-1:0]             k_q;
  logic [base_addr_size-1:0] addr_q;
  logic [wordsize-1:0]       wdata_q;
  logic                      we_q;
  logic [wordsize-1:0]       rdata_q;

  logic [wordsize-1:0]       cpu_data_out_q;
  logic                      cpu_ready_q;
  logic                      per_enable_q;
  logic [base_addr_size-1:0] per_addr_q;
  logic [7:0]                per_data_out_q;
  logic                      per_write_en_q;

`ifdef REFLET_BRIDGE_BYTE_ACCESS_EN
  logic                      byte_acc_q;
`else
  logic                      byte_acc_q;
  assign byte_acc_q = 1'b0;
`endif

  logic [KW-1:0]             last_k_d;
  logic [KW-1:0]             k_d;
  logic [wordsize-1:0]       rdata_d;
  logic [wordsize-1:0]       read_word_d;
  logic [wordsize-1:0]       wshift_d;
  logic [7:0]                per_wdata_d;
  logic [base_addr_size-1:0] per_addr_d;

  // Next-byte address/data and the read word including the byte on the bus now.
  always_comb begin
    last_k_d              = byte_acc_q ? '0 : KW'(NBYTES - 1);
    k_d                   = k_q + 1'b1;
    per_addr_d            = addr_q + base_addr_size'(k_d);
    wshift_d              = wdata_q >> {k_d, 3'b000};
    per_wdata_d           = wshift_d[7:0];
    rdata_d               = rdata_q;
    rdata_d[8*k_q +: 8]   = per_data_in;
    read_word_d           = byte_acc_q ? wordsize'(rdata_d[7:0]) : rdata_d;
  end

  // Control FSM; peripheral outputs are registered one edge ahead of the
  // byte they describe so they are valid for the whole ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      rdata_q        <= '0;
      cpu_data_out_q <= '0;
      cpu_ready_q    <= 1'b0;
      per_enable_q   <= 1'b0;
      per_addr_q     <= '0;
      per_data_out_q <= '0;
      per_write_en_q <= 1'b0;
`ifdef REFLET_BRIDGE_BYTE_ACCESS_EN
      byte_acc_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cpu_ready_q <= 1'b0;
          if (cpu_req) begin
            state_q        <= ACCESS;
            k_q            <= '0;
            addr_q         <= cpu_addr;
            wdata_q        <= cpu_data_in;
            we_q           <= cpu_write_en;
`ifdef REFLET_BRIDGE_BYTE_ACCESS_EN
            byte_acc_q     <= cpu_byte_access;
`endif
            per_enable_q   <= 1'b1;
            per_addr_q     <= cpu_addr;
            per_write_en_q <= cpu_write_en;
            per_data_out_q <= cpu_write_en ? cpu_data_in[7:0] : '0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= rdata_d;
          end
          if (k_q == last_k_d) begin
            state_q        <= DONE;
            cpu_ready_q    <= 1'b1;
            per_enable_q   <= 1'b0;
            per_addr_q     <= '0;
            per_data_out_q <= '0;
            per_write_en_q <= 1'b0;
            if (!we_q) begin
              cpu_data_out_q <= read_word_d;
            end
          end else begin
            k_q            <= k_d;
            per_addr_q     <= per_addr_d;
            per_data_out_q <= we_q ? per_wdata_d : '0;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cpu_ready_q <= 1'b0;
          k_q         <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign cpu_ready    = cpu_ready_q;
  assign per_enable   = per_enable_q;
  assign per_addr     = per_addr_q;
  assign per_data_out = per_data_out_q;
  assign per_write_en = per_write_en_q;

endmodule
